bpu_ctrl: RTL and testbench

//  Sequences the branch predictor table. Tracks in-flight IF predictions in fetch order and checks each against the
//  ID-stage resolution. On mispredict it issues a one-cycle PC redirect and flushes wrong-path entries. Outcome

---
 rtl/bpu_pkg.sv | 32 +++
 rtl/bpu_fifo.sv | 46 ++++
 rtl/bpu_ctrl.sv | 155 +++++++++++++++
 tb/tb_bpu_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared widths, state encoding and entry layouts for the branch predictor controller.
package bpu_pkg;

  localparam int REG_W       = 32;
  localparam int NUM_ENTRIES = 64;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
  localparam int IF_DEPTH    = 4;
  localparam int UPD_DEPTH   = 4;

  typedef enum logic [1:0] {
    BPU_INIT  = 2'd0,
    BPU_RUN   = 2'd1,
    BPU_FLUSH = 2'd2
  } bpu_state_e;

  typedef struct packed {
    logic [REG_W-1:0] pc;
    logic             pd_taken;
    logic [REG_W-1:0] pd_target;
  } if_entry_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             clear;
    logic             taken;
    logic [REG_W-1:0] target;
  } upd_entry_t;

  localparam int IF_ENTRY_W  = $bits(if_entry_t);
  localparam int UPD_ENTRY_W = $bits(upd_entry_t);

endpackage

// File: rtl/bpu_fifo.sv
// Small synchronous FIFO with synchronous clear; pointers carry one extra wrap bit.
module bpu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bpu_ctrl.sv
// Branch predictor sequencer: post-reset table sweep, in-flight prediction
// tracking, mispredict redirect and queued outcome writes.
module bpu_ctrl
  import bpu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_valid_i,
  input  logic [REG_W-1:0] if_pc_i,
  input  logic             if_pdTaken_i,
  input  logic [REG_W-1:0] if_pdTargetPc_i,
  output logic             if_stall_o,
  input  logic             id_valid_i,
  input  logic             id_isBranch_i,
  input  logic             id_taken_i,
  input  logic [REG_W-1:0] id_targetPc_i,
  output logic             redirect_valid_o,
  output logic [REG_W-1:0] redirect_pc_o,
  output logic             pd_wrEn_o,
  output logic [IDX_W-1:0] pd_wrIndex_o,
  output logic             pd_wrClear_o,
  output logic             pd_wrTaken_o,
  output logic [REG_W-1:0] pd_wrTargetPc_o,
  input  logic             pd_wrReady_i,
  output logic [15:0]      dropCnt_o
);

  bpu_state_e       state;
  bpu_state_e       state_nxt;
  logic [IDX_W-1:0] sweep_idx;

  if_entry_t        if_din;
  if_entry_t        if_head;
  logic             if_push;
  logic             if_pop;
  logic             if_clr;
  logic             if_full;
  logic             if_empty;

  upd_entry_t       upd_din;
  upd_entry_t       upd_head;
  logic             upd_push;
  logic             upd_pop;
  logic             upd_full;
  logic             upd_empty;
  logic             drop_now;

  logic             mispredict;
  logic             flush_now;
  logic [REG_W-1:0] correct_pc;

  assign if_stall_o = (state == BPU_INIT) | if_full;
  assign if_push    = (state == BPU_RUN) & if_valid_i & ~if_stall_o;
  assign if_pop     = (state == BPU_RUN) & id_valid_i & ~if_empty;
  assign if_din     = '{pc: if_pc_i, pd_taken: if_pdTaken_i, pd_target: if_pdTargetPc_i};

  always_comb begin
    mispredict = 1'b0;
    correct_pc = if_head.pc + REG_W'(4);
    if (id_isBranch_i)
      mispredict = (id_taken_i != if_head.pd_taken) |
                   (id_taken_i & (id_targetPc_i != if_head.pd_target));
    else
      mispredict = if_head.pd_taken;
    if (id_taken_i) correct_pc = id_targetPc_i;
  end

  assign flush_now = if_pop & mispredict;
  assign if_clr    = rst_i | flush_now;

  // Non-branches that were predicted taken evict the aliasing entry.
  assign upd_push = if_pop & (id_isBranch_i | if_head.pd_taken);
  always_comb begin
    upd_din        = '0;
    upd_din.index  = if_head.pc[IDX_W+1:2];
    upd_din.clear  = ~id_isBranch_i;
    upd_din.taken  = id_isBranch_i & id_taken_i;
    upd_din.target = id_isBranch_i ? id_targetPc_i : '0;
  end

  assign upd_pop  = ~rst_i & (state != BPU_INIT) & ~upd_empty & pd_wrReady_i;
  assign drop_now = upd_push & upd_full & ~upd_pop;

  bpu_fifo #(.WIDTH(IF_ENTRY_W), .DEPTH(IF_DEPTH)) u_if_fifo (
    .clk   (clk_i),
    .clr   (if_clr),
    .push  (if_push),
    .din   (if_din),
    .pop   (if_pop),
    .dout  (if_head),
    .full  (if_full),
    .empty (if_empty)
  );

  bpu_fifo #(.WIDTH(UPD_ENTRY_W), .DEPTH(UPD_DEPTH)) u_upd_fifo (
    .clk   (clk_i),
    .clr   (rst_i),
    .push  (upd_push),
    .din   (upd_din),
    .pop   (upd_pop),
    .dout  (upd_head),
    .full  (upd_full),
    .empty (upd_empty)
  );

  always_comb begin
    pd_wrEn_o       = 1'b0;
    pd_wrIndex_o    = sweep_idx;
    pd_wrClear_o    = 1'b1;
    pd_wrTaken_o    = 1'b0;
    pd_wrTargetPc_o = '0;
    if (!rst_i) begin
      if (state == BPU_INIT) begin
        pd_wrEn_o = 1'b1;
      end else begin
        pd_wrEn_o       = ~upd_empty;
        pd_wrIndex_o    = upd_head.index;
        pd_wrClear_o    = upd_head.clear;
        pd_wrTaken_o    = upd_head.taken;
        pd_wrTargetPc_o = upd_head.target;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BPU_INIT:  if (pd_wrReady_i && sweep_idx == IDX_W'(NUM_ENTRIES-1)) state_nxt = BPU_RUN;
      BPU_RUN:   if (flush_now) state_nxt = BPU_FLUSH;
      BPU_FLUSH: state_nxt = BPU_RUN;
      default:   state_nxt = BPU_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= BPU_INIT;
      sweep_idx        <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      dropCnt_o        <= '0;
    end else begin
      state            <= state_nxt;
      redirect_valid_o <= flush_now;
      if (flush_now) redirect_pc_o <= correct_pc;
      if (state == BPU_INIT && pd_wrReady_i) sweep_idx <= sweep_idx + IDX_W'(1);
      if (drop_now && dropCnt_o != 16'hFFFF) dropCnt_o <= dropCnt_o + 16'd1;
    end
  end

  // ID must never resolve when nothing is in flight.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(state == BPU_RUN && id_valid_i && if_empty));

endmodule

// File: tb/tb_bpu_ctrl.sv
// Scoreboard bench for bpu_ctrl: a queue-based reference model predicts table
// writes and redirects; a negedge monitor compares against what the DUT presents.
module tb_bpu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        if_pdTaken_i = 1'b0;
  logic [31:0] if_pdTargetPc_i = '0;
  logic        if_stall_o;
  logic        id_valid_i = 1'b0;
  logic        id_isBranch_i = 1'b0;
  logic        id_taken_i = 1'b0;
  logic [31:0] id_targetPc_i = '0;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        pd_wrEn_o;
  logic [5:0]  pd_wrIndex_o;
  logic        pd_wrClear_o;
  logic        pd_wrTaken_o;
  logic [31:0] pd_wrTargetPc_o;
  logic        pd_wrReady_i = 1'b1;
  logic [15:0] dropCnt_o;

  bpu_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_pdTaken_i(if_pdTaken_i),
    .if_pdTargetPc_i(if_pdTargetPc_i), .if_stall_o(if_stall_o),
    .id_valid_i(id_valid_i), .id_isBranch_i(id_isBranch_i), .id_taken_i(id_taken_i),
    .id_targetPc_i(id_targetPc_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .pd_wrEn_o(pd_wrEn_o), .pd_wrIndex_o(pd_wrIndex_o), .pd_wrClear_o(pd_wrClear_o),
    .pd_wrTaken_o(pd_wrTaken_o), .pd_wrTargetPc_o(pd_wrTargetPc_o),
    .pd_wrReady_i(pd_wrReady_i), .dropCnt_o(dropCnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; bit pdt; logic [31:0] tgt; } fetch_t;
  typedef struct { int idx; bit clr; bit tk; logic [31:0] tgt; } wr_t;

  fetch_t      inf_q[$];
  wr_t         upd_q[$];
  wr_t         exp_wr[$];
  logic [31:0] exp_redir[$];

  int  m_mode;   // 0 = sweeping, 1 = running, 2 = flushing
  int  m_sweep;
  int  m_drops;
  bit  exp_stall, exp_wren, exp_rv;
  int  exp_drop;
  bit  mon_en = 1'b0;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: event with no expectation queued (t=%0t)", name, $time);
  endtask

  task automatic enqueue(wr_t w);
    if (upd_q.size() < 4) begin
      upd_q.push_back(w);
      exp_wr.push_back(w);
    end else if (m_drops < 65535) begin
      m_drops++;
    end
  endtask

  // Advance the reference model across the coming clock edge, using the inputs now applied.
  task automatic step();
    fetch_t      h;
    bit          mis;
    logic [31:0] redir;
    exp_stall = (m_mode == 0) || (inf_q.size() == 4);
    exp_wren  = !rst_i && ((m_mode == 0) || (upd_q.size() > 0));
    exp_rv    = (m_mode == 2);
    exp_drop  = m_drops;
    if (rst_i) begin
      m_mode = 0; m_sweep = 0; m_drops = 0;
      inf_q.delete(); upd_q.delete(); exp_wr.delete();
      return;
    end
    if (m_mode == 0) begin
      if (pd_wrReady_i) begin
        exp_wr.push_back('{m_sweep, 1'b1, 1'b0, 32'h0});
        if (m_sweep == 63) m_mode = 1;
        m_sweep++;
      end
      return;
    end
    if (upd_q.size() > 0 && pd_wrReady_i) void'(upd_q.pop_front());
    if (m_mode == 2) begin
      m_mode = 1;
      return;
    end
    mis = 1'b0;
    redir = '0;
    if (id_valid_i && inf_q.size() > 0) begin
      h = inf_q.pop_front();
      if (id_isBranch_i) begin
        mis = (id_taken_i != h.pdt) || (id_taken_i && id_targetPc_i != h.tgt);
        enqueue('{int'((h.pc >> 2) % 64), 1'b0, id_taken_i, id_targetPc_i});
      end else begin
        mis = h.pdt;
        if (h.pdt) enqueue('{int'((h.pc >> 2) % 64), 1'b1, 1'b0, 32'h0});
      end
      redir = id_taken_i ? id_targetPc_i : h.pc + 32'd4;
    end
    if (if_valid_i && !exp_stall) inf_q.push_back('{if_pc_i, if_pdTaken_i, if_pdTargetPc_i});
    if (mis) begin
      inf_q.delete();
      exp_redir.push_back(redir);
      m_mode = 2;
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("if_stall", if_stall_o, exp_stall);
      chk("wr_en", pd_wrEn_o, exp_wren);
      chk("drop_cnt", dropCnt_o, exp_drop);
      chk("redirect_valid", redirect_valid_o, exp_rv);
      if (redirect_valid_o) begin
        if (exp_redir.size() == 0) fail_now("redirect_extra");
        else chk("redirect_pc", redirect_pc_o, exp_redir.pop_front());
      end
      if (pd_wrEn_o && pd_wrReady_i) begin
        if (exp_wr.size() == 0) fail_now("wr_extra");
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_index", pd_wrIndex_o, e.idx);
          chk("wr_clear", pd_wrClear_o, e.clr);
          if (!e.clr) begin
            chk("wr_taken", pd_wrTaken_o, e.tk);
            chk("wr_target", pd_wrTargetPc_o, e.tgt);
          end
        end
      end
    end
  end

  task automatic cycle();
    step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(bit ifv, logic [31:0] pc, bit pdt, logic [31:0] ptg,
                     bit idv, bit br, bit tk, logic [31:0] tg);
    if_valid_i = ifv; if_pc_i = pc; if_pdTaken_i = pdt; if_pdTargetPc_i = ptg;
    id_valid_i = idv; id_isBranch_i = br; id_taken_i = tk; id_targetPc_i = tg;
    cycle();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic count_sweep(string name);
    int n;
    n = 0;
    while (if_stall_o && n < 200) begin
      idle(1);
      n++;
    end
    chk(name, n, 64);
  endtask

  initial begin
    m_mode = 0; m_sweep = 0; m_drops = 0;
    rst_i = 1'b1;
    pd_wrReady_i = 1'b1;
    cycle();
    mon_en = 1'b1;
    rst_i = 1'b0;
    chk("reset_redirect_pc", redirect_pc_o, 32'h0);
    chk("reset_stall", if_stall_o, 1);
    count_sweep("sweep_len");

    // Sweep interrupted at index 20 restarts from 0.
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    idle(20);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    count_sweep("sweep_restart_len");
    chk("run_after_sweep", if_stall_o, 0);

    // Correct prediction.
    drv(1, 32'h8000_0010, 0, 32'h0, 0, 0, 0, 32'h0);
    drv(0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h8000_0014);
    chk("t2_no_redirect", redirect_valid_o, 0);
    idle(3);

    // Direction miss with two younger wrong-path fetches.
    drv(1, 32'h8000_0020, 0, 32'h0, 0, 0, 0, 32'h0);
    drv(1, 32'h8000_0024, 0, 32'h0, 0, 0, 0, 32'h0);
    drv(1, 32'h8000_0028, 0, 32'h0, 0, 0, 0, 32'h0);
    drv(0, 32'h0, 0, 32'h0, 1, 1, 1, 32'h8000_0100);
    chk("t3_redirect_valid", redirect_valid_o, 1);
    chk("t3_redirect_pc", redirect_pc_o, 32'h8000_0100);
    idle(1);
    chk("t3_redirect_pulse", redirect_valid_o, 0);
    idle(3);

    // Target miss.
    drv(1, 32'h8000_0030, 1, 32'h8000_0200, 0, 0, 0, 32'h0);
    drv(0, 32'h0, 0, 32'h0, 1, 1, 1, 32'h8000_0300);
    chk("t4_redirect_pc", redirect_pc_o, 32'h8000_0300);
    idle(4);

    // Non-branch predicted taken.
    drv(1, 32'h8000_0040, 1, 32'h8000_0500, 0, 0, 0, 32'h0);
    drv(0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0);
    chk("t5_redirect_pc", redirect_pc_o, 32'h8000_0044);
    idle(4);

    // Backpressure: five resolutions into a four-deep update queue.
    pd_wrReady_i = 1'b0;
    for (int i = 0; i < 4; i++) drv(1, 32'h8000_0100 + 32'(i * 4), 0, 32'h0, 0, 0, 0, 32'h0);
    chk("t6_full_stall", if_stall_o, 1);
    drv(1, 32'h8000_0180, 0, 32'h0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) drv(0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0);
    drv(1, 32'h8000_0110, 0, 32'h0, 0, 0, 0, 32'h0);
    drv(0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0);
    chk("t6_drop_cnt", dropCnt_o, 1);
    pd_wrReady_i = 1'b1;
    idle(6);
    chk("t6_drained", exp_wr.size(), 0);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 1200; c++) begin
      pd_wrReady_i    = ($urandom_range(0, 9) < 7);
      if_valid_i      = $urandom_range(0, 1);
      if_pc_i         = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
      if_pdTaken_i    = $urandom_range(0, 1);
      if_pdTargetPc_i = 32'h8000_1000 + ($urandom_range(0, 3) << 4);
      id_valid_i      = (m_mode == 1) && (inf_q.size() > 0) && ($urandom_range(0, 2) != 0);
      id_isBranch_i   = ($urandom_range(0, 4) != 0);
      if (inf_q.size() > 0 && $urandom_range(0, 3) != 0) id_taken_i = inf_q[0].pdt;
      else id_taken_i = $urandom_range(0, 1);
      if (inf_q.size() > 0 && $urandom_range(0, 3) != 0) id_targetPc_i = inf_q[0].tgt;
      else id_targetPc_i = 32'h8000_1000 + ($urandom_range(0, 3) << 4);
      cycle();
    end

    pd_wrReady_i = 1'b1;
    idle(12);
    chk("final_wr_queue_empty", exp_wr.size(), 0);
    chk("final_redirect_queue_empty", exp_redir.size(), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
